// File: rtl/sum_window_accumulator.sv
// sum_window_accumulator: saturating WINDOW-sample accumulator with held result handshake (optional out_sat via SUM_WIN_SAT_FLAG_EN)
module sum_window_accumulator #(
  parameter int ACC_W  = 8,
  parameter int WINDOW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc
`ifdef SUM_WIN_SAT_FLAG_EN
  ,
  output logic             out_sat
`endif
);
  localparam int CW = WINDOW > 1 ? $clog2(WINDOW) : 1;
  localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);
  localparam logic [ACC_W:0] MAX = {1'b0, {ACC_W{1'b1}}};
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, out_acc_q, out_acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ACC_W:0] sum;
  logic clamp;
`ifdef SUM_WIN_SAT_FLAG_EN
  logic sat_sticky_q, sat_sticky_d, out_sat_q, out_sat_d;
`endif
  assign sum = {1'b0, acc_q} + (ACC_W + 1)'(in_sum);
  assign clamp = sum > MAX;
  assign in_ready = state_q == ACCUM;
  assign out_valid = state_q == HOLD;
  assign out_acc = out_acc_q;
`ifdef SUM_WIN_SAT_FLAG_EN
  assign out_sat = out_sat_q;
`endif
  // next-state: clear aborts everything, ACCUM folds in samples, HOLD waits for the consumer
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    out_acc_d = out_acc_q;
`ifdef SUM_WIN_SAT_FLAG_EN
    sat_sticky_d = sat_sticky_q;
    out_sat_d = out_sat_q;
`endif
    if (clear) begin
      state_d = ACCUM;
      acc_d = '0;
      cnt_d = '0;
      out_acc_d = '0;
`ifdef SUM_WIN_SAT_FLAG_EN
      sat_sticky_d = 1'b0;
      out_sat_d = 1'b0;
`endif
    end else if (state_q == ACCUM) begin
      if (in_valid) begin
        acc_d = clamp ? MAX[ACC_W-1:0] : sum[ACC_W-1:0];
`ifdef SUM_WIN_SAT_FLAG_EN
        sat_sticky_d = sat_sticky_q | clamp;
        out_sat_d = cnt_q == LAST ? sat_sticky_d : out_sat_q;
`endif
        out_acc_d = cnt_q == LAST ? acc_d : out_acc_q;
        state_d = cnt_q == LAST ? HOLD : ACCUM;
        cnt_d = cnt_q == LAST ? cnt_q : cnt_q + 1'b1;
      end
    end else if (out_ready) begin
      state_d = ACCUM;
      acc_d = '0;
      cnt_d = '0;
`ifdef SUM_WIN_SAT_FLAG_EN
      sat_sticky_d = 1'b0;
`endif
    end
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q <= '0;
      cnt_q <= '0;
      out_acc_q <= '0;
`ifdef SUM_WIN_SAT_FLAG_EN
      sat_sticky_q <= 1'b0;
      out_sat_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      out_acc_q <= out_acc_d;
`ifdef SUM_WIN_SAT_FLAG_EN
      sat_sticky_q <= sat_sticky_d;
      out_sat_q <= out_sat_d;
`endif
    end
  end
endmodule

// File: tb/tb_sum_window_accumulator.sv
// tb_sum_window_accumulator: scoreboard bench over three parameterisations (8/16, 6/16, 8/1)
module tb_sum_window_accumulator;
  typedef struct {int id; int acc; bit sat;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic iv [3];
  logic ordy [3];
  logic [3:0] isum [3];
  logic ir [3];
  logic ov [3];
  logic os [3];
  logic [7:0] oa0, oa2;
  logic [5:0] oa1;
  int checks = 0;
  int errors = 0;
  exp_t sb [$];
  exp_t mon_e;
  always #5 clk = ~clk;
  sum_window_accumulator #(.ACC_W(8), .WINDOW(16)) d0 (.clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_sum(isum[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_acc(oa0)
`ifdef SUM_WIN_SAT_FLAG_EN
    , .out_sat(os[0])
`endif
  );
  sum_window_accumulator #(.ACC_W(6), .WINDOW(16)) d1 (.clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_sum(isum[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_acc(oa1)
`ifdef SUM_WIN_SAT_FLAG_EN
    , .out_sat(os[1])
`endif
  );
  sum_window_accumulator #(.ACC_W(8), .WINDOW(1)) d2 (.clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(iv[2]), .in_ready(ir[2]), .in_sum(isum[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_acc(oa2)
`ifdef SUM_WIN_SAT_FLAG_EN
    , .out_sat(os[2])
`endif
  );
`ifndef SUM_WIN_SAT_FLAG_EN
  initial for (int i = 0; i < 3; i++) os[i] = 1'b0;
`endif
  function automatic int oa_of(int i);
    return i == 0 ? int'(oa0) : i == 1 ? int'(oa1) : int'(oa2);
  endfunction
  // output monitor: every output handshake pops and checks the oldest expected result
  always @(negedge clk) begin
    if (rst_n && !clear) begin
      for (int i = 0; i < 3; i++) begin
        if (ov[i] && ordy[i]) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL result_unexpected dut%0d got acc=%0d, no result expected", i, oa_of(i));
          end else begin
            mon_e = sb.pop_front();
            if (mon_e.id != i || oa_of(i) !== mon_e.acc || ir[i] !== 1'b0) begin
              errors++;
              $display("FAIL result dut%0d got acc=%0d in_ready=%0b, required dut%0d acc=%0d in_ready=0", i, oa_of(i), ir[i], mon_e.id, mon_e.acc);
            end
`ifdef SUM_WIN_SAT_FLAG_EN
            checks++;
            if (os[i] !== mon_e.sat) begin
              errors++;
              $display("FAIL result_sat dut%0d got %0b, required %0b", i, os[i], mon_e.sat);
            end
`endif
          end
        end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string name, int got, int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d, required %0d", name, got, want);
    end
  endtask
  task automatic send(int i, int v);
    iv[i] = 1'b1;
    isum[i] = 4'(v);
    for (int k = 0; k < 100; k++) begin
      if (ir[i]) begin
        step();
        iv[i] = 1'b0;
        return;
      end
      step();
    end
    iv[i] = 1'b0;
    chk("send_timeout", 0, 1);
  endtask
  task automatic run_window(int i, int n, int v, int w);
    int s = 0;
    bit sat = 1'b0;
    int mx = (1 << w) - 1;
    for (int k = 0; k < n; k++) begin
      s = s + v;
      if (s > mx) begin
        s = mx;
        sat = 1'b1;
      end
    end
    sb.push_back('{i, s, sat});
    for (int k = 0; k < n; k++) send(i, v);
  endtask
  task automatic test_reset();
    #3;
    chk("reset_in_ready", int'(ir[0]), 1);
    chk("reset_out_valid", int'(ov[0]), 0);
    chk("reset_out_acc", int'(oa0), 0);
    chk("reset_out_sat", int'(os[0]), 0);
    #20 rst_n = 1'b1;
    step();
  endtask
  task automatic test_basic();
    run_window(0, 16, 3, 8);
    chk("basic_out_valid", int'(ov[0]), 1);
    chk("basic_in_ready_hold", int'(ir[0]), 0);
    chk("basic_acc", int'(oa0), 48);
    step();
    chk("basic_out_valid_after", int'(ov[0]), 0);
    chk("basic_in_ready_after", int'(ir[0]), 1);
  endtask
  task automatic test_saturation();
    run_window(1, 16, 15, 6);
    chk("sat_acc", int'(oa1), 63);
    step();
    run_window(1, 16, 1, 6);
    chk("sat_followup_acc", int'(oa1), 16);
    step();
  endtask
  task automatic test_backpressure();
    ordy[0] = 1'b0;
    run_window(0, 16, 2, 8);
    iv[0] = 1'b1;
    isum[0] = 4'd9;
    for (int k = 0; k < 10; k++) begin
      chk("bp_out_valid", int'(ov[0]), 1);
      chk("bp_acc", int'(oa0), 32);
      chk("bp_in_ready", int'(ir[0]), 0);
      step();
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    step();
    chk("bp_release_in_ready", int'(ir[0]), 1);
    run_window(0, 16, 5, 8);
    step();
  endtask
  task automatic test_clear();
    for (int k = 0; k < 7; k++) send(0, 9);
    clear = 1'b1;
    step();
    clear = 1'b0;
    run_window(0, 16, 1, 8);
    step();
    ordy[0] = 1'b0;
    for (int k = 0; k < 16; k++) send(0, 2);
    chk("clear_hold_valid", int'(ov[0]), 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_hold_out_valid", int'(ov[0]), 0);
    chk("clear_hold_out_acc", int'(oa0), 0);
    chk("clear_hold_in_ready", int'(ir[0]), 1);
    ordy[0] = 1'b1;
  endtask
  task automatic test_async_reset();
    for (int k = 0; k < 5; k++) send(0, 4);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_win_in_ready", int'(ir[0]), 1);
    chk("arst_win_out_valid", int'(ov[0]), 0);
    #2 rst_n = 1'b1;
    step();
    run_window(0, 16, 4, 8);
    chk("arst_fresh_acc", int'(oa0), 64);
    step();
    ordy[0] = 1'b0;
    for (int k = 0; k < 16; k++) send(0, 7);
    chk("arst_hold_valid", int'(ov[0]), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_hold_out_valid", int'(ov[0]), 0);
    chk("arst_hold_out_acc", int'(oa0), 0);
    chk("arst_hold_in_ready", int'(ir[0]), 1);
    #2 rst_n = 1'b1;
    ordy[0] = 1'b1;
    step();
    run_window(0, 16, 4, 8);
    chk("arst_hold_fresh_acc", int'(oa0), 64);
    step();
  endtask
  task automatic test_window1();
    int vals [3] = '{5, 0, 15};
    for (int k = 0; k < 3; k++) begin
      run_window(2, 1, vals[k], 8);
      chk("w1_out_valid", int'(ov[2]), 1);
      chk("w1_acc", int'(oa2), vals[k]);
      step();
      chk("w1_gap_out_valid", int'(ov[2]), 0);
      step();
    end
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0;
      ordy[i] = 1'b1;
      isum[i] = 4'd0;
    end
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_window1();
    repeat (3) step();
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
